edge_event_queue: RTL and testbench
===================================

EDGE_EVENT_QUEUE -- requirements
Module: edge_event_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of event entries (power of two, 2..16).
REQ-002 Parameter: TS_W, 16, timestamp width in bits.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: pedge  in  8  per-bit rising-edge pulse vector from the upstream edge detector, sampled every clk.
REQ-006 Port: evt_valid  out  1  head entry available.
REQ-007 Port: evt_ready  in  1  consumer accepts head entry.
REQ-008 Port: evt_bits  out  8  pedge vector of head entry.
REQ-009 Port: evt_time  out  TS_W  timestamp of head entry.
REQ-010 Port: evt_count  out  $clog2(DEPTH)+1  number of stored entries.
REQ-011 Port: overflow  out  1  sticky flag: at least one event dropped.
REQ-012 Port: drop_cnt  out  8  saturating count of dropped events.
REQ-013 Port: clr_overflow  in  1  synchronous clear of overflow and drop_cnt.

Function
REQ-014 The block SHALL keep a free-running TS_W-bit timestamp counter, +1 every cycle, wrapping all-ones -> 0.
REQ-015 A cycle with pedge != 0 SHALL be a push request of entry {pedge, current timestamp value (pre-increment)}.
REQ-016 A cycle with pedge == 0 SHALL push nothing.
REQ-017 A pop SHALL occur in a cycle where evt_valid && evt_ready.
REQ-018 Entries SHALL leave in push order (FIFO).
REQ-019 Latency: an entry pushed in cycle N SHALL be visible on evt_valid/evt_bits/evt_time in cycle N+1 at the earliest; no combinational path pedge -> outputs.
REQ-020 evt_valid SHALL equal (evt_count != 0); evt_bits and evt_time SHALL be 0 when evt_count == 0.
REQ-021 Head outputs SHALL remain stable while evt_valid && !evt_ready.
REQ-022 Push while not full SHALL be accepted; evt_count += 1 unless a pop occurs the same cycle.
REQ-023 Push and pop in the same cycle SHALL leave evt_count unchanged, including when full (slot freed by pop is reused) and when count == 1.
REQ-024 Push while full without pop SHALL drop the entry, set overflow, and increment drop_cnt saturating at 255; stored entries unchanged.
REQ-025 evt_ready while empty SHALL have no effect.
REQ-026 clr_overflow SHALL clear overflow and drop_cnt next cycle; if a drop occurs in the same cycle, the drop wins: overflow = 1, drop_cnt = 1.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; full/empty derived from evt_count.

Reset
REQ-028 On rst_n low, asynchronously: timestamp = 0, evt_count = 0, pointers = 0, evt_valid = 0, evt_bits = 0, evt_time = 0, overflow = 0, drop_cnt = 0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; first cycle after release has timestamp 0.
REQ-030 Storage array contents need not be reset; no stale entry SHALL be observable.

Structure
REQ-031 Package edge_evt_pkg SHALL hold DEPTH/TS_W defaults and the packed entry type evt_t {bits[7:0], time[TS_W-1:0]}.
REQ-032 Storage and pointers SHALL live in one sub-module edge_evt_fifo (generic synchronous FIFO of evt_t, push/pop/full/empty/count); top holds timestamp, push qualification and overflow logic.

Verification
REQ-033 Reset release, pedge = 0 for 10 cycles -> evt_valid = 0, evt_count = 0, overflow = 0 throughout.
REQ-034 pedge = 0x01 in the cycle where timestamp = 3, evt_ready = 0 -> next cycle evt_valid = 1, evt_bits = 0x01, evt_time = 3, held stable until evt_ready = 1.
REQ-035 evt_ready = 0, pedge = 0x06 for 6 consecutive cycles starting at timestamp 10 (DEPTH = 4) -> evt_count = 4, entries times 10..13, overflow = 1, drop_cnt = 2; then clr_overflow -> overflow = 0, drop_cnt = 0.
REQ-036 Full queue, evt_ready = 1 and pedge = 0x80 same cycle -> evt_count stays 4, new tail bits 0x80, overflow stays 0.
REQ-037 Timestamp at 0xFFFF with pedge = 0x10, next cycle pedge = 0x20 -> entries (0x10, 0xFFFF), (0x20, 0x0000) in order.
REQ-038 rst_n pulsed low with 3 entries queued and overflow = 1 -> all outputs 0 immediately; after release, first push at cycle 0 reports evt_time = 0.

Source files
------------

// File: rtl/edge_evt_pkg.sv
// Shared defaults and entry layout for the edge event queue.
// An entry is the captured pedge vector plus the timestamp of the cycle it arrived in.
package edge_evt_pkg;

   localparam int unsigned EVT_DEPTH  = 4;
   localparam int unsigned EVT_TS_W   = 16;
   localparam int unsigned EVT_BITS_W = 8;

   // Field 'ts' holds the event time; 'time' is a reserved word.
   typedef struct packed {
      logic [EVT_BITS_W-1:0] bits;
      logic [EVT_TS_W-1:0]   ts;
   } evt_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/edge_evt_fifo.sv
// Generic synchronous FIFO with registered pointers/count and a zero-masked head.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module edge_evt_fifo
   import edge_evt_pkg::*;
#(
   parameter int unsigned DEPTH = EVT_DEPTH,
   parameter int unsigned W     = $bits(evt_t)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [W-1:0]           i_data,
   output logic [W-1:0]           o_head_c,
   output logic                   o_full_c,
   output logic                   o_empty_c,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty_c = (r_count == '0);
   assign o_full_c  = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty_c;
   assign w_do_push = i_push && (!o_full_c || w_do_pop);

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
         else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

   // Storage is not reset, so hide whatever sits at the read pointer while empty.
   assign o_head_c = o_empty_c ? '0 : r_mem[r_rptr];
   assign o_count  = r_count;

endmodule

// File: rtl/edge_event_queue.sv
// Timestamps non-zero pedge vectors and queues them for a ready/valid consumer.
// Drops on a full queue are flagged by a sticky overflow bit and a saturating drop counter.
module edge_event_queue
   import edge_evt_pkg::*;
#(
   parameter int unsigned DEPTH = EVT_DEPTH,
   parameter int unsigned TS_W  = EVT_TS_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             pedge,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [7:0]             evt_bits,
   output logic [TS_W-1:0]        evt_time,
   output logic [$clog2(DEPTH):0] evt_count,
   output logic                   overflow,
   output logic [7:0]             drop_cnt,
   input  logic                   clr_overflow
);

   localparam int unsigned W = EVT_BITS_W + TS_W;

   logic [TS_W-1:0] r_ts;
   logic            r_overflow;
   logic [7:0]      r_drop_cnt;
   logic            w_push_req;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic            w_drop;
   logic [W-1:0]    w_head;

   assign w_push_req = (pedge != '0);
   assign w_pop      = evt_valid && evt_ready;
   assign w_drop     = w_push_req && w_full && !w_pop;

   edge_evt_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (w_push_req),
      .i_pop     (w_pop),
      .i_data    ({pedge, r_ts}),
      .o_head_c  (w_head),
      .o_full_c  (w_full),
      .o_empty_c (w_empty),
      .o_count   (evt_count)
   );

   assign evt_valid = !w_empty;
   assign evt_bits  = w_head[W-1 -: EVT_BITS_W];
   assign evt_time  = w_head[TS_W-1:0];
   assign overflow  = r_overflow;
   assign drop_cnt  = r_drop_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ts <= '0;
      else        r_ts <= r_ts + TS_W'(1);
   end

   // A drop in the same cycle as a clear restarts the count at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         r_drop_cnt <= clr_overflow ? 8'd1 : sat_inc8(r_drop_cnt);
      end else if (clr_overflow) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_edge_event_queue.sv
// Self-checking bench for edge_event_queue: a queue model acts as scoreboard for the
// head entry every cycle, with a vector table and hand sequences for the corner cases.
module tb_edge_event_queue;
   import edge_evt_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TS_W  = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [7:0]      pedge = '0;
   logic            evt_valid;
   logic            evt_ready = 1'b0;
   logic [7:0]      evt_bits;
   logic [TS_W-1:0] evt_time;
   logic [2:0]      evt_count;
   logic            overflow;
   logic [7:0]      drop_cnt;
   logic            clr_overflow = 1'b0;

   edge_event_queue #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pedge        (pedge),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_bits     (evt_bits),
      .evt_time     (evt_time),
      .evt_count    (evt_count),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_fail = 0;
   evt_t       q[$];
   logic [15:0] m_ts  = '0;
   logic        m_ovf = 1'b0;
   logic [7:0]  m_drop = '0;

   typedef struct {
      logic [7:0] pe;
      logic       rdy;
      logic       clr;
      int         cnt;
      logic       ovf;
      int         drp;
   } vec_t;
   vec_t tbl[18];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_outputs();
      evt_t h;
      h = '0;
      if (q.size() != 0) h = q[0];
      chk("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
      chk("evt_count", 32'(evt_count), 32'(q.size()));
      chk("evt_bits",  32'(evt_bits),  32'(h.bits));
      chk("evt_time",  32'(evt_time),  32'(h.ts));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
   endtask

   // Called on a falling edge: check current state, drive inputs, advance model one cycle.
   task automatic step(input logic [7:0] pe, input logic rdy, input logic clr);
      logic pop, full, drop;
      evt_t e;
      check_outputs();
      pedge = pe; evt_ready = rdy; clr_overflow = clr;
      pop  = (q.size() != 0) && rdy;
      full = (q.size() == DEPTH);
      drop = (pe != 0) && full && !pop;
      if (pop) void'(q.pop_front());
      if (pe != 0 && !drop) begin
         e.bits = pe; e.ts = m_ts;
         q.push_back(e);
      end
      if (drop) begin
         m_ovf  = 1'b1;
         m_drop = clr ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
      end else if (clr) begin
         m_ovf = 1'b0; m_drop = '0;
      end
      m_ts = m_ts + 16'd1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; pedge = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
      #1;
      chk("rst_valid",    32'(evt_valid), 32'd0);
      chk("rst_count",    32'(evt_count), 32'd0);
      chk("rst_bits",     32'(evt_bits),  32'd0);
      chk("rst_time",     32'(evt_time),  32'd0);
      chk("rst_overflow", 32'(overflow),  32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt),  32'd0);
      q.delete(); m_ts = '0; m_ovf = 1'b0; m_drop = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Fill six pushes from ts 10, clear, full push+pop, clear vs drop, drain, count==1 push+pop.
      tbl[0]  = '{8'h06, 1'b0, 1'b0, 1, 1'b0, 0};
      tbl[1]  = '{8'h06, 1'b0, 1'b0, 2, 1'b0, 0};
      tbl[2]  = '{8'h06, 1'b0, 1'b0, 3, 1'b0, 0};
      tbl[3]  = '{8'h06, 1'b0, 1'b0, 4, 1'b0, 0};
      tbl[4]  = '{8'h06, 1'b0, 1'b0, 4, 1'b1, 1};
      tbl[5]  = '{8'h06, 1'b0, 1'b0, 4, 1'b1, 2};
      tbl[6]  = '{8'h00, 1'b0, 1'b1, 4, 1'b0, 0};
      tbl[7]  = '{8'h80, 1'b1, 1'b0, 4, 1'b0, 0};
      tbl[8]  = '{8'h01, 1'b0, 1'b1, 4, 1'b1, 1};
      tbl[9]  = '{8'h00, 1'b0, 1'b1, 4, 1'b0, 0};
      tbl[10] = '{8'h00, 1'b1, 1'b0, 3, 1'b0, 0};
      tbl[11] = '{8'h00, 1'b1, 1'b0, 2, 1'b0, 0};
      tbl[12] = '{8'h00, 1'b1, 1'b0, 1, 1'b0, 0};
      tbl[13] = '{8'h00, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[14] = '{8'h00, 1'b1, 1'b0, 0, 1'b0, 0};
      tbl[15] = '{8'h04, 1'b0, 1'b0, 1, 1'b0, 0};
      tbl[16] = '{8'h08, 1'b1, 1'b0, 1, 1'b0, 0};
      tbl[17] = '{8'h00, 1'b1, 1'b0, 0, 1'b0, 0};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 10; i++) step(8'h00, 1'b0, 1'b0);
      chk("ts_before_table", 32'(m_ts), 32'd10);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i].pe, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("tbl%0d_count", i), 32'(evt_count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
         chk($sformatf("tbl%0d_drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].drp));
      end

      // Single push at timestamp 3, held while the consumer stalls.
      do_reset();
      for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0);
      step(8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0);
      chk("held_time", 32'(evt_time), 32'd3);
      chk("held_bits", 32'(evt_bits), 32'h01);
      step(8'h00, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b0);

      // Drop counter saturation, then leave three entries queued with overflow set.
      for (int i = 0; i < 262; i++) step(8'hFF, 1'b0, 1'b0);
      chk("drop_sat", 32'(drop_cnt), 32'd255);
      step(8'h00, 1'b1, 1'b0);
      chk("pre_reset_count", 32'(evt_count), 32'd3);
      chk("pre_reset_overflow", 32'(overflow), 32'd1);

      // Mid-operation reset, then a push in the very first cycle after release.
      do_reset();
      step(8'h01, 1'b0, 1'b0);
      chk("post_reset_time", 32'(evt_time), 32'd0);
      chk("post_reset_valid", 32'(evt_valid), 32'd1);
      step(8'h00, 1'b1, 1'b0);

      // Timestamp wrap: run idle up to 0xFFFF, then push across the wrap.
      evt_ready = 1'b0; pedge = '0; clr_overflow = 1'b0;
      while (m_ts != 16'hFFFF) begin
         @(posedge clk);
         m_ts = m_ts + 16'd1;
      end
      @(negedge clk);
      step(8'h10, 1'b0, 1'b0);
      chk("wrap_first_time", 32'(evt_time), 32'hFFFF);
      step(8'h20, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0);
      chk("wrap_second_time", 32'(evt_time), 32'h0000);
      chk("wrap_second_bits", 32'(evt_bits), 32'h20);
      step(8'h00, 1'b1, 1'b0);
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
